// File: rtl/panel_io_ctrl.sv
// Front-panel controller: LED channels with static/blink modes, a counted
// beep pattern generator and debounced buttons with press/release/long-press
// events. All timing derives from a shared tick prescaled from aclk.
module panel_io_ctrl #(
  parameter int N_LEDS         = 6,
  parameter int N_BTNS         = 2,
  parameter int CLK_HZ         = 100000000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_T     = 20,
  parameter int LONG_T         = 1000,
  parameter int BLINK_T        = 250,
  parameter int BEEP_ON_T      = 100,
  parameter int BEEP_OFF_T     = 100,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [2*N_LEDS-1:0] led_mode,
  output logic [N_LEDS-1:0]   leds_o,
  input  logic                beep_req,
  input  logic [3:0]          beep_count,
  input  logic                beep_abort,
  output logic                beep_busy,
  output logic                beep_o,
  input  logic [N_BTNS-1:0]   btn_i,
  output logic [N_BTNS-1:0]   btn_level,
  output logic [N_BTNS-1:0]   btn_press,
  output logic [N_BTNS-1:0]   btn_release,
  output logic [N_BTNS-1:0]   btn_long
);

  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(DIV);
  localparam int BLINK_W  = (BLINK_T > 1) ? $clog2(BLINK_T) : 1;
  localparam int DB_W     = (DEBOUNCE_T > 1) ? $clog2(DEBOUNCE_T) : 1;
  localparam int LONG_W   = $clog2(LONG_T + 1);
  localparam int BEEP_MAX = (BEEP_ON_T > BEEP_OFF_T) ? BEEP_ON_T : BEEP_OFF_T;
  localparam int BT_W     = (BEEP_MAX > 1) ? $clog2(BEEP_MAX) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_T - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_T - 1);
  localparam logic [LONG_W-1:0]  LONG_LAST  = LONG_W'(LONG_T - 1);
  localparam logic [LONG_W-1:0]  LONG_SAT   = LONG_W'(LONG_T);
  localparam logic [BT_W-1:0]    ON_LAST    = BT_W'(BEEP_ON_T - 1);
  localparam logic [BT_W-1:0]    OFF_LAST   = BT_W'(BEEP_OFF_T - 1);
  localparam logic [N_BTNS-1:0]  BTN_INV    = {N_BTNS{BTN_ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {BEEP_IDLE, BEEP_ON, BEEP_OFF} beep_state_e;

  logic [PRE_W-1:0]              pre_q, pre_d;
  logic                          tick_q, tick_d;
  logic [BLINK_W-1:0]            blink_q, blink_d;
  logic                          phase_q, phase_d;
  logic [N_LEDS-1:0]             leds_q, leds_d;
  logic [N_BTNS-1:0]             sync1_q, sync2_q, btn_s;
  logic [N_BTNS-1:0][DB_W-1:0]   db_q, db_d;
  logic [N_BTNS-1:0][LONG_W-1:0] hold_q, hold_d;
  logic [N_BTNS-1:0]             level_q, level_d, press_q, press_d;
  logic [N_BTNS-1:0]             release_q, release_d, long_q, long_d;
  beep_state_e                   state_q, state_d;
  logic [3:0]                    remain_q, remain_d;
  logic [BT_W-1:0]               btimer_q, btimer_d;
  logic                          beep_q, beep_d, busy_q, busy_d;

  // Pressed buttons read as 1 from here on regardless of pin polarity.
  assign btn_s = sync2_q ^ BTN_INV;

  // Timebase: one-cycle tick each time the prescaler wraps; blink phase and LED drive.
  always_comb begin
    // NOTE: every _d takes its _q value (or a safe constant) first, so no path can infer a latch.
    tick_d  = (pre_q == PRE_LAST);
    pre_d   = tick_d ? '0 : pre_q + 1'b1;
    blink_d = blink_q;
    phase_d = phase_q;
    leds_d  = '0;
    if (tick_q) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    for (int i = 0; i < N_LEDS; i++) begin
      case (led_mode[2*i +: 2])
        2'b00:   leds_d[i] = 1'b0;
        2'b01:   leds_d[i] = 1'b1;
        2'b10:   leds_d[i] = phase_q;
        default: leds_d[i] = ~phase_q;
      endcase
    end
  end

  // Per-button debounce, edge events and saturating long-press hold counter.
  always_comb begin
    db_d      = db_q;
    level_d   = level_q;
    hold_d    = hold_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_BTNS; i++) begin
      if (btn_s[i] == level_q[i]) begin
        db_d[i] = '0;
      end else if (tick_q) begin
        if (db_q[i] == DB_LAST) begin
          db_d[i]      = '0;
          level_d[i]   = btn_s[i];
          press_d[i]   = btn_s[i];
          release_d[i] = ~btn_s[i];
        end else begin
          db_d[i] = db_q[i] + 1'b1;
        end
      end
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_q && (hold_q[i] != LONG_SAT)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_q[i] == LONG_LAST);
      end
    end
  end

  // Beeper next-state: counted ON/OFF pattern, abort overrides everything.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    btimer_d = btimer_q;
    case (state_q)
      BEEP_IDLE: begin
        if (beep_req && (beep_count != 4'd0)) begin
          remain_d = beep_count;
          btimer_d = '0;
          state_d  = BEEP_ON;
        end
      end
      BEEP_ON: begin
        if (tick_q) begin
          if (btimer_q == ON_LAST) begin
            remain_d = remain_q - 4'd1;
            btimer_d = '0;
            state_d  = (remain_q == 4'd1) ? BEEP_IDLE : BEEP_OFF;
          end else begin
            btimer_d = btimer_q + 1'b1;
          end
        end
      end
      BEEP_OFF: begin
        if (tick_q) begin
          if (btimer_q == OFF_LAST) begin
            btimer_d = '0;
            state_d  = BEEP_ON;
          end else begin
            btimer_d = btimer_q + 1'b1;
          end
        end
      end
      default: state_d = BEEP_IDLE;
    endcase
    if (beep_abort) begin
      state_d  = BEEP_IDLE;
      remain_d = '0;
      btimer_d = '0;
    end
    beep_d = (state_d == BEEP_ON);
    busy_d = (state_d != BEEP_IDLE);
  end

  // State registers; every flop clears on reset, including mid-pattern and mid-debounce.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      leds_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      hold_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      state_q   <= BEEP_IDLE;
      remain_q  <= '0;
      btimer_q  <= '0;
      beep_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, like real hardware.
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      leds_q    <= leds_d;
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      state_q   <= state_d;
      remain_q  <= remain_d;
      btimer_q  <= btimer_d;
      beep_q    <= beep_d;
      busy_q    <= busy_d;
    end
  end

  assign leds_o      = leds_q;
  assign beep_o      = beep_q;
  assign beep_busy   = busy_q;
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Self-checking bench for panel_io_ctrl: a tick-level behavioural model is
// compared against every output on every cycle, and directed scenarios pin
// the model with hand-computed literal expectations.
module tb_panel_io_ctrl;

  localparam int N_LEDS = 4, N_BTNS = 2, CLK_HZ = 1000, TICK_HZ = 100;
  localparam int DEBOUNCE_T = 3, LONG_T = 10, BLINK_T = 2;
  localparam int BEEP_ON_T = 2, BEEP_OFF_T = 1, BTN_ACTIVE_LOW = 1;
  localparam int DIV = CLK_HZ / TICK_HZ;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic [2*N_LEDS-1:0] led_mode;
  logic [N_LEDS-1:0]   leds_o;
  logic                beep_req, beep_abort, beep_busy, beep_o;
  logic [3:0]          beep_count;
  logic [N_BTNS-1:0]   btn_i, btn_level, btn_press, btn_release, btn_long;

  panel_io_ctrl #(
    .N_LEDS(N_LEDS), .N_BTNS(N_BTNS), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
    .DEBOUNCE_T(DEBOUNCE_T), .LONG_T(LONG_T), .BLINK_T(BLINK_T),
    .BEEP_ON_T(BEEP_ON_T), .BEEP_OFF_T(BEEP_OFF_T), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .led_mode(led_mode), .leds_o(leds_o),
    .beep_req(beep_req), .beep_count(beep_count), .beep_abort(beep_abort),
    .beep_busy(beep_busy), .beep_o(beep_o), .btn_i(btn_i), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (tick-count view) ----------------
  int              m_edges, m_ntick, m_start, m_total;
  bit              m_tick, m_busy;
  logic [1:0]      m_s1, m_s2;
  int              m_db [N_BTNS];
  int              m_hold [N_BTNS];
  logic [N_LEDS-1:0] e_leds = '0;
  logic [N_BTNS-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;
  logic              e_beep = 1'b0, e_busy = 1'b0;

  task automatic model_reset();
    m_edges = 0; m_ntick = 0; m_tick = 1'b0; m_busy = 1'b0; m_start = 0; m_total = 0;
    m_s1 = '1; m_s2 = '1;  // cleared synchroniser flops read as "pressed" after inversion
    for (int i = 0; i < N_BTNS; i++) begin m_db[i] = 0; m_hold[i] = 0; end
    e_leds = '0; e_level = '0; e_press = '0; e_release = '0; e_long = '0;
    e_beep = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    logic [N_BTNS-1:0] old_level;
    int k;
    t = m_tick;
    for (int i = 0; i < N_LEDS; i++) begin
      logic [1:0] md;
      bit ph;
      md = led_mode[2*i +: 2];
      ph = ((m_ntick / BLINK_T) % 2) == 1;
      case (md)
        2'd0: e_leds[i] = 1'b0;
        2'd1: e_leds[i] = 1'b1;
        2'd2: e_leds[i] = ph;
        default: e_leds[i] = !ph;
      endcase
    end
    m_ntick = m_ntick + int'(t);
    old_level = e_level;
    e_press = '0; e_release = '0; e_long = '0;
    for (int i = 0; i < N_BTNS; i++) begin
      if (!old_level[i]) m_hold[i] = 0;
      else if (t && m_hold[i] < LONG_T) begin
        m_hold[i]++;
        if (m_hold[i] == LONG_T) e_long[i] = 1'b1;
      end
      if (m_s2[i] == old_level[i]) m_db[i] = 0;
      else if (t) begin
        m_db[i]++;
        if (m_db[i] == DEBOUNCE_T) begin
          m_db[i] = 0;
          e_level[i] = m_s2[i];
          if (m_s2[i]) e_press[i] = 1'b1; else e_release[i] = 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = (BTN_ACTIVE_LOW != 0) ? ~btn_i : btn_i;
    if (beep_abort) m_busy = 1'b0;
    else if (!m_busy && beep_req && beep_count != 4'd0) begin
      m_busy  = 1'b1;
      m_start = m_ntick;
      m_total = int'(beep_count) * BEEP_ON_T + (int'(beep_count) - 1) * BEEP_OFF_T;
    end
    e_beep = 1'b0;
    if (m_busy) begin
      k = m_ntick - m_start;
      if (k >= m_total) m_busy = 1'b0;
      else e_beep = (k % (BEEP_ON_T + BEEP_OFF_T)) < BEEP_ON_T;
    end
    e_busy = m_busy;
    m_edges++;
    m_tick = (m_edges % DIV) == 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial forever begin
    @(negedge aclk);
    if (chk_en) begin
      check("leds_o", leds_o, e_leds);
      check("beep_o", beep_o, e_beep);
      check("beep_busy", beep_busy, e_busy);
      check("btn_level", btn_level, e_level);
      check("btn_press", btn_press, e_press);
      check("btn_release", btn_release, e_release);
      check("btn_long", btn_long, e_long);
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int cyc = 0, n_press0 = 0, n_press1 = 0, n_rel0 = 0, n_long0 = 0, n_rise = 0;
  int press_cyc = 0, long_cyc = 0, on_run = 0, off_run = 0, last_on = 0, last_off = 0;
  int beep_fall_cyc = 0, busy_fall_cyc = 0;
  logic prev_beep = 1'b0, prev_busy = 1'b0;

  initial forever begin
    @(negedge aclk);
    cyc++;
    if (btn_press[0] === 1'b1) begin n_press0++; press_cyc = cyc; end
    if (btn_press[1] === 1'b1) n_press1++;
    if (btn_release[0] === 1'b1) n_rel0++;
    if (btn_long[0] === 1'b1) begin n_long0++; long_cyc = cyc; end
    if (beep_o === 1'b1) begin
      if (!prev_beep) n_rise++;
      on_run++;
    end else begin
      if (prev_beep) begin last_on = on_run; beep_fall_cyc = cyc; end
      on_run = 0;
    end
    if (beep_o === 1'b0 && beep_busy === 1'b1) off_run++;
    else begin
      if (off_run > 0) last_off = off_run;
      off_run = 0;
    end
    if (prev_busy && beep_busy === 1'b0) busy_fall_cyc = cyc;
    prev_beep = beep_o;
    prev_busy = beep_busy;
  end

  task automatic step(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] cnt, input logic abort);
    beep_count = cnt; beep_req = 1'b1; beep_abort = abort;
    step(1);
    beep_req = 1'b0; beep_abort = 1'b0; beep_count = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int p0, r0, l0, rise0, run;
    bit found;
    logic prev;
    aresetn = 1'b0; led_mode = 8'b11_10_01_00; btn_i = 2'b11;
    beep_req = 1'b0; beep_count = 4'd0; beep_abort = 1'b0;
    step(2);
    chk_en = 1'b1;
    step(3);
    check("rst_leds", leds_o, 4'b0000);
    check("rst_beep", {beep_o, beep_busy}, 2'b00);
    check("rst_btn", {btn_level, btn_press, btn_release, btn_long}, 8'h00);
    aresetn = 1'b1;

    // Blink: static channels and 20-cycle anti-phase toggling
    step(5);
    check("led1_static_on", leds_o[1], 1'b1);
    check("led0_static_off", leds_o[0], 1'b0);
    found = 1'b0; prev = leds_o[2];
    for (int c = 0; c < 100 && !found; c++) begin step(1); if (leds_o[2] !== prev) found = 1'b1; end
    check("led2_toggle_seen", found, 1'b1);
    found = 1'b0; prev = leds_o[2]; run = 0;
    for (int c = 0; c < 100 && !found; c++) begin step(1); run++; if (leds_o[2] !== prev) found = 1'b1; end
    check("led2_half_period", run, 20);
    check("led2_led3_antiphase", leds_o[2] ^ leds_o[3], 1'b1);

    // Debounce: 2-tick glitch gives nothing
    p0 = n_press0; r0 = n_rel0; l0 = n_long0;
    btn_i[0] = 1'b0; step(20); btn_i[0] = 1'b1; step(60);
    check("glitch_no_press", n_press0 - p0, 0);
    check("glitch_level", btn_level[0], 1'b0);

    // Long press: one press, one long 100 cycles later, one release
    btn_i[0] = 1'b0; step(40);
    check("press_count", n_press0 - p0, 1);
    check("press_level", btn_level, 2'b01);
    step(130);
    check("long_count", n_long0 - l0, 1);
    check("long_delay", long_cyc - press_cyc, 100);
    btn_i[0] = 1'b1; step(50);
    check("release_count", n_rel0 - r0, 1);
    check("release_level", btn_level[0], 1'b0);

    // Short hold: press and release, no long
    btn_i[0] = 1'b0; step(80); btn_i[0] = 1'b1; step(60);
    check("short_press", n_press0 - p0, 2);
    check("short_release", n_rel0 - r0, 2);
    check("short_no_long", n_long0 - l0, 1);
    check("btn1_quiet", n_press1, 0);

    // Beep pattern of three; a mid-pattern request is ignored
    rise0 = n_rise;
    pulse_req(4'd3, 1'b0);
    check("beep_start", {beep_o, beep_busy}, 2'b11);
    step(39);
    check("beep_mid_busy", beep_busy, 1'b1);
    pulse_req(4'd5, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin step(1); if (beep_busy === 1'b0) found = 1'b1; end
    check("beep_done", found, 1'b1);
    check("beep_pulses", n_rise - rise0, 3);
    check("beep_last_on", last_on, 2 * DIV);
    check("beep_last_gap", last_off, DIV);
    check("busy_falls_with_beep", busy_fall_cyc - beep_fall_cyc, 0);
    step(60);
    check("beep_no_extend", n_rise - rise0, 3);

    // Zero count, request with abort, abort while on
    pulse_req(4'd0, 1'b0); step(4);
    check("zero_count_idle", beep_busy, 1'b0);
    pulse_req(4'd2, 1'b1);
    check("req_abort_idle", {beep_o, beep_busy}, 2'b00);
    step(3);
    pulse_req(4'd2, 1'b0); step(3);
    check("abort_pre_on", beep_o, 1'b1);
    beep_abort = 1'b1; step(1); beep_abort = 1'b0;
    check("abort_off_next", {beep_o, beep_busy}, 2'b00);
    step(30);

    // Reset mid-pattern and mid-debounce
    pulse_req(4'd4, 1'b0); step(4);
    btn_i[1] = 1'b0; step(25);
    check("pre_reset_busy", beep_busy, 1'b1);
    aresetn = 1'b0; #1;
    check("async_clear_beep", {beep_o, beep_busy}, 2'b00);
    check("async_clear_leds", leds_o, 4'b0000);
    btn_i[1] = 1'b1; step(3);
    aresetn = 1'b1;
    rise0 = n_rise;
    step(60);
    check("no_stale_press", n_press1, 0);
    check("no_stale_beep", n_rise - rise0, 0);
    check("post_reset_idle", {beep_busy, btn_level}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/panel_io_ctrl.md
Name: panel_io_ctrl

Overview:
- PL-side front-panel controller driven by PS GPIO.
- Generalised in channel count: N_LEDS LED channels with static and blink modes, a counted-pattern beeper, and N_BTNS debounced buttons.
- Each button reports its level plus press, release and long-press events.
- Sits between the zynq block design GPIO/fabric clock and the board LED, beeper and button pins.

Parameters:
N_LEDS, 6, number of LED channels (1..32)
N_BTNS, 2, number of buttons (1..8)
CLK_HZ, 100000000, aclk frequency
TICK_HZ, 1000, internal timebase rate; CLK_HZ/TICK_HZ must be an integer >= 2
DEBOUNCE_T, 20, ticks an input must be stable before it is committed
LONG_T, 1000, ticks held before a long-press event
BLINK_T, 250, ticks per blink half-period
BEEP_ON_T, 100, ticks beeper on per beep
BEEP_OFF_T, 100, ticks beeper off between beeps
BTN_ACTIVE_LOW, 1, 1 means a pin reads 0 when the button is pressed

Ports:
aclk  in  1  fabric clock
aresetn  in  1  reset, asynchronous assert, active-low
led_mode  in  2*N_LEDS  per channel: 00 off, 01 on, 10 blink, 11 blink anti-phase
leds_o  out  N_LEDS  LED drive, 1 = lit
beep_req  in  1  one-cycle request to start a pattern
beep_count  in  4  number of beeps, sampled with beep_req
beep_abort  in  1  stop the beeper immediately
beep_busy  out  1  pattern in progress
beep_o  out  1  beeper drive
btn_i  in  N_BTNS  raw asynchronous button pins
btn_level  out  N_BTNS  debounced state, 1 = pressed
btn_press  out  N_BTNS  one-cycle pulse on a debounced press
btn_release  out  N_BTNS  one-cycle pulse on a debounced release
btn_long  out  N_BTNS  one-cycle pulse after LONG_T ticks held

Behaviour:
- Interface: one clock, aclk. Reset aresetn is asynchronous and active-low. Every flop clears on aresetn=0, including mid-pattern and mid-debounce.
- Reset values: all outputs 0, blink phase 0, beeper FSM in IDLE, debounced state = released.
- Tick prescaler:
  - Counter runs 0..CLK_HZ/TICK_HZ-1.
  - tick is asserted for one cycle when the counter wraps.
  - First tick occurs CLK_HZ/TICK_HZ cycles after reset release.
- Blink:
  - Tick counter 0..BLINK_T-1; phase toggles when the counter wraps.
  - Mode 10 drives phase; mode 11 drives ~phase.
  - Modes 00/01 drive 0/1.
  - leds_o is registered: one cycle of latency from led_mode or the phase change.
- Button input conditioning:
  - btn_i passes through a 2-flop synchroniser, then is inverted when BTN_ACTIVE_LOW=1.
- Debounce, per button:
  - While the synchronised input equals the committed state, the counter is held at 0.
  - While they differ, the counter increments on each tick.
  - On reaching DEBOUNCE_T the state is committed and the counter cleared.
  - A glitch shorter than DEBOUNCE_T ticks causes no event.
- Button events:
  - btn_press or btn_release fires in the same cycle that btn_level changes.
- Long-press, per button:
  - Hold counter clears on press and increments on ticks while btn_level=1.
  - btn_long pulses once when the counter reaches LONG_T.
  - The counter saturates at LONG_T: no repeat until release and a new press.
  - Release before LONG_T gives no btn_long.
- Beeper FSM, states IDLE, ON, OFF:
  - IDLE: on beep_req=1 with beep_count!=0, latch remaining=beep_count, clear the timer, go to ON.
  - IDLE: beep_req with beep_count=0 is ignored.
  - ON: beep_o=1; the timer counts ticks. On the BEEP_ON_T-th tick, decrement remaining. If the result is 0 go to IDLE, else clear the timer and go to OFF.
  - OFF: beep_o=0; on the BEEP_OFF_T-th tick go to ON.
  - beep_busy=1 in ON and OFF.
  - beep_req while busy is ignored; the pattern is not restarted or extended.
  - beep_abort has priority over beep_req in all states. It forces IDLE, and beep_o=0 and beep_busy=0 on the next cycle.
  - beep_o and beep_busy are registered and go high the cycle after an accepted request.
- All width arithmetic: counters are sized to $clog2 of their maximum + 1. No wrap occurs other than the wraps specified above.

Test Plan (bench parameters: CLK_HZ=1000, TICK_HZ=100 so tick=10 cycles, DEBOUNCE_T=3, LONG_T=10, BLINK_T=2, BEEP_ON_T=2, BEEP_OFF_T=1, N_LEDS=4, N_BTNS=2):
- Reset/blink: hold aresetn=0, set led_mode=8'b11_10_01_00 → all outputs 0 during reset; after release, leds_o[1]=1 constantly, leds_o[0]=0, and leds_o[2]/leds_o[3] toggle every 20 cycles in opposite phase.
- Debounce: drive btn_i[0]=0 for 2 ticks then 1 → no events. Then hold 0 for ≥4 ticks → exactly one btn_press[0], btn_level[0]=1; btn[1] stays idle.
- Long press: hold btn0 for 12 ticks → one btn_long[0] 10 ticks after btn_press, no second pulse. Release → one btn_release[0] after 3 ticks. A 5-tick hold gives press and release, no btn_long.
- Beep pattern: beep_req with beep_count=3 → three high pulses of 2 ticks separated by 1-tick gaps. beep_busy falls with the third pulse. beep_req with count=5 mid-pattern has no effect.
- Abort/zero: beep_req with count=0 → beep_busy stays 0. beep_req and beep_abort in the same cycle → stays IDLE. Abort during ON → beep_o=0 next cycle.
- Reset mid-operation: assert aresetn low during ON and during a debounce count → immediate clear; no stale event after release.
